lru_way_alloc_ctrl: RTL and testbench
=====================================

Name: lru_way_alloc_ctrl

Overview:
- Sequencing controller for the LRU doubly-linked-list tracker in a set-associative cache set.
- Accepts lookup results (hit/miss plus hit way) over a valid/ready handshake and picks a victim on a miss.
- Victim is the lowest invalid way, otherwise the tracker's lru_way.
- Runs the fill handshake and issues exactly one touch pulse per completed request to the tracker's access port.

Parameters:
- NUM_WAYS, 4, number of ways; power of two, 2 or more.
- PTR_WIDTH, $clog2(NUM_WAYS), way index width (localparam).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid  in  1  lookup request present.
- req_ready  out  1  controller can accept a request.
- req_hit  in  1  tag matched.
- req_hit_way  in  PTR_WIDTH  matching way.
- invalidate_all  in  1  clear all valid bits.
- fill_req_valid  out  1  fill of fill_req_way requested.
- fill_req_way  out  PTR_WIDTH  way to fill.
- fill_done  in  1  fill complete (single-cycle pulse).
- lru_access_valid  out  1  touch pulse to the LRU tracker.
- lru_access_way  out  PTR_WIDTH  way to mark MRU.
- lru_way  in  PTR_WIDTH  current LRU way from the tracker.
- resp_valid  out  1  request completed (1-cycle pulse).
- resp_way  out  PTR_WIDTH  way that was used.
- resp_is_fill  out  1  completion came from a miss/fill.
- way_valid  out  NUM_WAYS  per-way valid bits.

Behaviour:
Clock and reset:
- Single clock clk; reset is synchronous, active-high.
- On reset: state=IDLE, way_valid=0, and all of fill_req_valid, lru_access_valid, resp_valid, resp_is_fill, fill_req_way, lru_access_way, resp_way are 0.
- Reset mid-FILL abandons the fill. fill_done is then ignored.

State machine (IDLE, FILL, TOUCH):
- req_ready = (state==IDLE) && !invalidate_all && !reset. It is combinational.
- IDLE:
  - invalidate_all=1: way_valid<=0, stay IDLE. Invalidate wins over a simultaneous req_valid.
  - Else on accept (req_valid && req_ready), latch the request.
  - Hit, defined as req_hit && way_valid[req_hit_way]: target=req_hit_way, go to TOUCH.
  - Otherwise it is a miss; a hit reported on an invalid way counts as a miss.
  - Miss: target = lowest-index way with way_valid=0; if all ways are valid, target=lru_way sampled in the accept cycle. Go to FILL.
- FILL:
  - fill_req_valid=1 and fill_req_way=target, held stable until fill_done.
  - fill_done is sampled only in FILL; fill_done in any other state is ignored.
  - On fill_done: way_valid[target]<=1, go to TOUCH.
  - invalidate_all during FILL is ignored.
- TOUCH (exactly one cycle):
  - lru_access_valid=1, lru_access_way=target.
  - resp_valid=1, resp_way=target, resp_is_fill=(came from FILL).
  - Next state is IDLE.

Latency and throughput:
- Hit: response in the cycle after accept.
- Miss: response in the cycle after fill_done.
- One request in flight; next accept earliest 2 cycles after the previous accept.
- Outputs other than req_ready are registered.

Optional Feature:
- Macro LRU_WAY_LOCK_EN.
- When defined:
  - Adds input lock_mask[NUM_WAYS] and output resp_err (1 bit).
  - Miss victim search: invalid ways first (lowest index, lock ignored); else lru_way if not locked; else the lowest-index valid unlocked way.
  - If every way is valid and locked: no fill. Go to TOUCH with lru_access_valid=0, resp_valid=1, resp_err=1, resp_way=0.
  - Hits are unaffected by locks.
- When undefined: no lock_mask or resp_err ports, and behaviour is exactly as above.

Decomposition:
- Package lru_pkg:
  - ctrl_state_t enum {IDLE, FILL, TOUCH}.
  - Shared NUM_WAYS default.
  - Function find_first_zero() for the invalid-way search.
- Sub-module lru_victim_select: combinational, computes the victim from way_valid, lru_way and (if enabled) lock_mask. Instantiated once.

Test Plan (NUM_WAYS=4, bench instantiates the LRU tracker driven by lru_access_*):
1. Reset, then four misses with a 2-cycle fill_done delay each -> fill_req_way 0,1,2,3 in order; way_valid=4'b1111; resp_is_fill=1 each time.
2. After test 1, hit on way 1 -> resp_valid one cycle after accept, resp_way=1, resp_is_fill=0, lru_access_valid pulse with way 1, no fill_req_valid.
3. All ways valid, tracker lru_way=0, then a miss -> fill_req_way=0; after fill_done, touch way 0; the next miss selects the new lru_way (2 after test 2 ordering).
4. invalidate_all asserted together with req_valid in IDLE -> req_ready=0, way_valid=0; a hit on way 2 next cycle is treated as a miss, fill_req_way=0.
5. Reset asserted during FILL, then fill_done pulse -> state IDLE, no resp_valid, no lru_access_valid, way_valid=0.
6. (LRU_WAY_LOCK_EN) all valid, lock_mask=4'b1111, miss -> resp_err=1, no fill_req_valid, no touch. With lock_mask=4'b0001 and lru_way=0 -> victim is way 1.

Source files
------------

// File: rtl/lru_pkg.sv
// Shared types and helpers for the LRU way allocation controller.
// Optional lock support is enabled with the LRU_WAY_LOCK_EN macro.
package lru_pkg;

    localparam int LRU_NUM_WAYS = 4;
    localparam int SEARCH_W     = 64;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        TOUCH
    } ctrl_state_t;

    // Index of the lowest zero bit; SEARCH_W when every bit is set.
    function automatic int find_first_zero(input logic [SEARCH_W-1:0] vec);
        find_first_zero = SEARCH_W;
        for (int i = SEARCH_W - 1; i >= 0; i--) begin
            if (!vec[i]) find_first_zero = i;
        end
    endfunction

endpackage

// File: rtl/lru_victim_select.sv
// Combinational miss-victim choice: lowest invalid way, else the LRU way.
// With LRU_WAY_LOCK_EN, locked valid ways are skipped; all-locked reports no_victim.
module lru_victim_select
    import lru_pkg::*;
#(
    parameter int  NUM_WAYS  = LRU_NUM_WAYS,
    localparam int PTR_WIDTH = $clog2(NUM_WAYS)
) (
`ifdef LRU_WAY_LOCK_EN
    input  logic [NUM_WAYS-1:0]  lock_mask,
`endif
    input  logic [NUM_WAYS-1:0]  way_valid,
    input  logic [PTR_WIDTH-1:0] lru_way,
    output logic [PTR_WIDTH-1:0] victim,
    output logic                 no_victim
);

    logic [SEARCH_W-1:0] valid_pad;
    int                  inv_idx;
`ifdef LRU_WAY_LOCK_EN
    logic [SEARCH_W-1:0] lock_pad;
    int                  unlocked_idx;
`endif

    always_comb begin
        // Ways beyond NUM_WAYS read as valid/locked so the search never picks them.
        valid_pad                 = '1;
        valid_pad[NUM_WAYS-1:0]   = way_valid;
        inv_idx                   = find_first_zero(valid_pad);
        victim                    = lru_way;
        no_victim                 = 1'b0;
`ifdef LRU_WAY_LOCK_EN
        lock_pad                  = '1;
        lock_pad[NUM_WAYS-1:0]    = lock_mask;
        unlocked_idx              = find_first_zero(lock_pad);
`endif
        if (!(&way_valid)) begin
            victim = PTR_WIDTH'(inv_idx);
        end
`ifdef LRU_WAY_LOCK_EN
        else if (lock_mask[lru_way]) begin
            if (&lock_mask) begin
                victim    = '0;
                no_victim = 1'b1;
            end else begin
                victim = PTR_WIDTH'(unlocked_idx);
            end
        end
`endif
    end

endmodule

// File: rtl/lru_way_alloc_ctrl.sv
// Request sequencer for a cache set: hit/miss handling, fill handshake and one LRU touch per request.
// Define LRU_WAY_LOCK_EN to add lock_mask/resp_err and lock-aware victim selection.
module lru_way_alloc_ctrl
    import lru_pkg::*;
#(
    parameter int  NUM_WAYS  = LRU_NUM_WAYS,
    localparam int PTR_WIDTH = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_hit,
    input  logic [PTR_WIDTH-1:0] req_hit_way,
    input  logic                 invalidate_all,
    output logic                 fill_req_valid,
    output logic [PTR_WIDTH-1:0] fill_req_way,
    input  logic                 fill_done,
    output logic                 lru_access_valid,
    output logic [PTR_WIDTH-1:0] lru_access_way,
    input  logic [PTR_WIDTH-1:0] lru_way,
    output logic                 resp_valid,
    output logic [PTR_WIDTH-1:0] resp_way,
    output logic                 resp_is_fill,
`ifdef LRU_WAY_LOCK_EN
    input  logic [NUM_WAYS-1:0]  lock_mask,
    output logic                 resp_err,
`endif
    output logic [NUM_WAYS-1:0]  way_valid
);

    ctrl_state_t          state, state_n;
    logic [PTR_WIDTH-1:0] target, target_n;
    logic                 from_fill, from_fill_n;
    logic                 err_q, err_n;
    logic [NUM_WAYS-1:0]  way_valid_n;
    logic [PTR_WIDTH-1:0] victim;
    logic                 no_victim;
    logic                 accept;

    lru_victim_select #(.NUM_WAYS(NUM_WAYS)) u_victim (
`ifdef LRU_WAY_LOCK_EN
        .lock_mask (lock_mask),
`endif
        .way_valid (way_valid),
        .lru_way   (lru_way),
        .victim    (victim),
        .no_victim (no_victim)
    );

    assign req_ready = (state == IDLE) && !invalidate_all && !reset;
    assign accept    = req_valid && req_ready;

`ifdef LRU_WAY_LOCK_EN
    assign resp_err = err_q;
`endif

    always_comb begin
        state_n     = state;
        target_n    = target;
        from_fill_n = from_fill;
        err_n       = 1'b0;
        way_valid_n = way_valid;
        case (state)
            IDLE: begin
                if (invalidate_all) begin
                    way_valid_n = '0;
                end else if (accept) begin
                    from_fill_n = 1'b0;
                    // A hit on an invalid way is really a miss.
                    if (req_hit && way_valid[req_hit_way]) begin
                        target_n = req_hit_way;
                        state_n  = TOUCH;
                    end else if (no_victim) begin
                        target_n = '0;
                        err_n    = 1'b1;
                        state_n  = TOUCH;
                    end else begin
                        target_n    = victim;
                        from_fill_n = 1'b1;
                        state_n     = FILL;
                    end
                end
            end
            FILL: begin
                if (fill_done) begin
                    way_valid_n[target] = 1'b1;
                    state_n             = TOUCH;
                end
            end
            TOUCH:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // All handshake outputs are registered from the next-state decode.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            target           <= '0;
            from_fill        <= 1'b0;
            err_q            <= 1'b0;
            way_valid        <= '0;
            fill_req_valid   <= 1'b0;
            fill_req_way     <= '0;
            lru_access_valid <= 1'b0;
            lru_access_way   <= '0;
            resp_valid       <= 1'b0;
            resp_way         <= '0;
            resp_is_fill     <= 1'b0;
        end else begin
            state            <= state_n;
            target           <= target_n;
            from_fill        <= from_fill_n;
            err_q            <= err_n;
            way_valid        <= way_valid_n;
            fill_req_valid   <= (state_n == FILL);
            fill_req_way     <= target_n;
            lru_access_valid <= (state_n == TOUCH) && !err_n;
            lru_access_way   <= target_n;
            resp_valid       <= (state_n == TOUCH);
            resp_way         <= target_n;
            resp_is_fill     <= (state_n == TOUCH) && from_fill_n;
        end
    end

endmodule

// File: tb/tb_lru_way_alloc_ctrl.sv
// Directed bench for lru_way_alloc_ctrl with an inline LRU order tracker driven by lru_access_*.
module tb_lru_way_alloc_ctrl;

    localparam int NW = 4;
    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_hit;
    logic [PW-1:0] req_hit_way;
    logic          invalidate_all;
    logic          fill_req_valid;
    logic [PW-1:0] fill_req_way;
    logic          fill_done;
    logic          lru_access_valid;
    logic [PW-1:0] lru_access_way;
    logic [PW-1:0] lru_way;
    logic          resp_valid;
    logic [PW-1:0] resp_way;
    logic          resp_is_fill;
    logic [NW-1:0] way_valid;
`ifdef LRU_WAY_LOCK_EN
    logic [NW-1:0] lock_mask;
    logic          resp_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    int n_resp = 0;
    int n_touch = 0;

    always #5 clk = ~clk;

    lru_way_alloc_ctrl #(.NUM_WAYS(NW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_hit          (req_hit),
        .req_hit_way      (req_hit_way),
        .invalidate_all   (invalidate_all),
        .fill_req_valid   (fill_req_valid),
        .fill_req_way     (fill_req_way),
        .fill_done        (fill_done),
        .lru_access_valid (lru_access_valid),
        .lru_access_way   (lru_access_way),
        .lru_way          (lru_way),
        .resp_valid       (resp_valid),
        .resp_way         (resp_way),
        .resp_is_fill     (resp_is_fill),
`ifdef LRU_WAY_LOCK_EN
        .lock_mask        (lock_mask),
        .resp_err         (resp_err),
`endif
        .way_valid        (way_valid)
    );

    // Tracker: ord[0] is LRU, ord[NW-1] is MRU.
    logic [NW-1:0][PW-1:0] ord;
    assign lru_way = ord[0];

    function automatic logic [NW-1:0][PW-1:0] touch_ord(input logic [NW-1:0][PW-1:0] o,
                                                       input logic [PW-1:0] w);
        logic [NW-1:0][PW-1:0] r;
        int k;
        r = o;
        k = 0;
        for (int i = 0; i < NW; i++) begin
            if (o[i] != w) begin
                r[k] = o[i];
                k++;
            end
        end
        r[NW-1] = w;
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) ord <= {2'd3, 2'd2, 2'd1, 2'd0};
        else if (lru_access_valid) ord <= touch_ord(ord, lru_access_way);
        if (resp_valid) n_resp <= n_resp + 1;
        if (lru_access_valid) n_touch <= n_touch + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one request at a negedge; returns #1 after the accepting edge.
    task automatic issue(input logic hit, input logic [PW-1:0] way);
        @(negedge clk);
        req_valid   = 1'b1;
        req_hit     = hit;
        req_hit_way = way;
        #1 chk("req_ready_idle", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic miss_fill(input logic [PW-1:0] exp_way, input int delay);
        chk("fill_req_valid", fill_req_valid, 1);
        chk("fill_req_way", fill_req_way, exp_way);
        chk("no_resp_in_fill", resp_valid, 0);
        repeat (delay) begin
            @(negedge clk);
            chk("fill_held_valid", fill_req_valid, 1);
            chk("fill_held_way", fill_req_way, exp_way);
        end
        @(negedge clk);
        fill_done = 1'b1;
        @(posedge clk);
        #1 fill_done = 1'b0;
        chk("miss_resp_valid", resp_valid, 1);
        chk("miss_resp_way", resp_way, exp_way);
        chk("miss_resp_is_fill", resp_is_fill, 1);
        chk("miss_touch_valid", lru_access_valid, 1);
        chk("miss_touch_way", lru_access_way, exp_way);
        chk("miss_fill_dropped", fill_req_valid, 0);
        @(posedge clk);
        #1 chk("miss_resp_pulse", resp_valid, 0);
    endtask

    task automatic hit_resp(input logic [PW-1:0] exp_way);
        chk("hit_resp_valid", resp_valid, 1);
        chk("hit_resp_way", resp_way, exp_way);
        chk("hit_resp_is_fill", resp_is_fill, 0);
        chk("hit_touch_valid", lru_access_valid, 1);
        chk("hit_touch_way", lru_access_way, exp_way);
        chk("hit_no_fill", fill_req_valid, 0);
        @(posedge clk);
        #1 chk("hit_resp_pulse", resp_valid, 0);
    endtask

    int r0, t0;

    initial begin
        reset          = 1'b1;
        req_valid      = 1'b0;
        req_hit        = 1'b0;
        req_hit_way    = '0;
        invalidate_all = 1'b0;
        fill_done      = 1'b0;
`ifdef LRU_WAY_LOCK_EN
        lock_mask      = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_way_valid", way_valid, 0);
        chk("rst_fill_valid", fill_req_valid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_touch_valid", lru_access_valid, 0);
        chk("rst_fill_way", fill_req_way, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("post_rst_ready", req_ready, 1);

        // 1: cold misses fill ways in index order
        for (int i = 0; i < NW; i++) begin
            issue(1'b0, 2'd0);
            miss_fill(PW'(i), 2);
        end
        chk("t1_way_valid", way_valid, 4'b1111);
        chk("t1_lru_way", lru_way, 0);

        // 2: hit on way 1
        issue(1'b1, 2'd1);
        hit_resp(2'd1);

        // 3: full set miss evicts LRU (0), then next miss takes way 2
        chk("t3_lru_way", lru_way, 0);
        issue(1'b0, 2'd0);
        miss_fill(2'd0, 1);
        issue(1'b0, 2'd3);
        miss_fill(2'd2, 0);

        // 4: invalidate beats a simultaneous request; a stale hit becomes a miss
        @(negedge clk);
        invalidate_all = 1'b1;
        req_valid      = 1'b1;
        req_hit        = 1'b1;
        req_hit_way    = 2'd2;
        #1 chk("t4_ready_blocked", req_ready, 0);
        @(posedge clk);
        #1;
        invalidate_all = 1'b0;
        req_valid      = 1'b0;
        chk("t4_way_valid_clr", way_valid, 0);
        chk("t4_no_fill", fill_req_valid, 0);
        chk("t4_no_resp", resp_valid, 0);
        issue(1'b1, 2'd2);
        miss_fill(2'd0, 1);
        chk("t4_way_valid", way_valid, 4'b0001);

        // 5: reset mid-fill abandons it; later fill_done is ignored
        issue(1'b0, 2'd0);
        chk("t5_fill_way", fill_req_way, 1);
        r0 = n_resp;
        t0 = n_touch;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset     = 1'b0;
        fill_done = 1'b1;
        @(posedge clk);
        #1 fill_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t5_resp_count", n_resp, r0);
        chk("t5_touch_count", n_touch, t0);
        chk("t5_way_valid", way_valid, 0);
        chk("t5_fill_valid", fill_req_valid, 0);
        chk("t5_idle_ready", req_ready, 1);

`ifdef LRU_WAY_LOCK_EN
        // 6: locked victim selection
        for (int i = 0; i < NW; i++) begin
            issue(1'b0, 2'd0);
            miss_fill(PW'(i), 0);
        end
        chk("t6_lru_way", lru_way, 0);
        lock_mask = 4'b1111;
        issue(1'b0, 2'd0);
        chk("t6_err_resp", resp_valid, 1);
        chk("t6_err_flag", resp_err, 1);
        chk("t6_err_way", resp_way, 0);
        chk("t6_err_no_touch", lru_access_valid, 0);
        chk("t6_err_no_fill", fill_req_valid, 0);
        @(posedge clk);
        #1 chk("t6_err_pulse", resp_err, 0);
        lock_mask = 4'b0001;
        issue(1'b0, 2'd0);
        miss_fill(2'd1, 0);
        lock_mask = 4'b1111;
        issue(1'b1, 2'd3);
        hit_resp(2'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
